// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet TX FIFO drain path.
package eth_tx_pkg;

    // Drain FSM states
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPad,
        StGap
    } drain_state_e;

    // Position of the last-of-frame flag inside a FIFO word
    localparam int unsigned LAST_BIT = 8;

    localparam int unsigned DEFAULT_MIN_LEN    = 60;
    localparam int unsigned DEFAULT_IFG_CYCLES = 12;

endpackage

// File: rtl/rd_prefetch_buf.sv
// Two-entry prefetch buffer in front of a non-fall-through FIFO read port.
// Tracks occupancy plus the word in flight and issues FIFO pops.
module rd_prefetch_buf
    import eth_tx_pkg::*;
#(
    parameter int unsigned DSIZE = 9
) (
    input  logic             rclk,
    input  logic             rrst,
    output logic             fifo_rinc_o,
    input  logic [DSIZE-1:0] fifo_rdata_i,
    input  logic             fifo_rempty_i,
    input  logic             pop_i,
    output logic             head_valid_o,
    output logic [7:0]       head_byte_o,
    output logic             head_last_o,
    output logic             incoming_o
);

    logic [1:0][DSIZE-1:0] mem_q, mem_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q;
    logic                  pop;
    logic [1:0]            occ_net;
    logic [2:0]            pending;

    assign pop = pop_i && (cnt_q != 2'd0);

    // The head leaving this cycle is already counted as gone, so a word can be
    // requested every cycle while the consumer drains one per cycle.
    assign occ_net     = cnt_q - {1'b0, pop};
    assign pending     = {1'b0, occ_net} + {2'b00, inflight_q};
    assign fifo_rinc_o = !fifo_rempty_i && (pending < 3'd2);

    assign head_valid_o = (cnt_q != 2'd0);
    assign head_byte_o  = mem_q[0][7:0];
    assign head_last_o  = mem_q[0][LAST_BIT];
    assign incoming_o   = inflight_q;

    // Buffer contents: entry 0 is always the head; write and pop may coincide
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        case ({inflight_q, pop})
            2'b01: begin
                mem_d[0] = mem_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    mem_d[0] = fifo_rdata_i;
                end else begin
                    mem_d[1] = fifo_rdata_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    mem_d[0] = fifo_rdata_i;
                end else begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = fifo_rdata_i;
                end
            end
            default: ;
        endcase
    end

    // State registers; a word popped during reset is dropped
    always_ff @(posedge rclk) begin
        if (rrst) begin
            mem_q      <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            cnt_q      <= cnt_d;
            inflight_q <= fifo_rinc_o;
        end
    end

endmodule

// File: rtl/eth_tx_fifo_drain.sv
// FIFO-to-stream drain for the TX MAC: runt padding and inter-frame gap.
module eth_tx_fifo_drain
    import eth_tx_pkg::*;
#(
    parameter int unsigned DSIZE      = 9,
    parameter int unsigned MIN_LEN    = DEFAULT_MIN_LEN,
    parameter int unsigned IFG_CYCLES = DEFAULT_IFG_CYCLES, // must be >= 1
    parameter int unsigned LEN_W      = 11
) (
    input  logic             rclk,
    input  logic             rrst,
    output logic             fifo_rinc,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             busy
);

    localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
    localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] CNT_MAX   = {LEN_W{1'b1}};

    drain_state_e     state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             done_q;
    logic [LEN_W-1:0] len_q;

    logic             buf_pop;
    logic             head_valid;
    logic [7:0]       head_byte;
    logic             head_last;
    logic             incoming;
    logic             buf_avail;
    logic [LEN_W-1:0] cnt_inc;
    logic             last_hs;

    rd_prefetch_buf #(
        .DSIZE(DSIZE)
    ) u_buf (
        .rclk         (rclk),
        .rrst         (rrst),
        .fifo_rinc_o  (fifo_rinc),
        .fifo_rdata_i (fifo_rdata),
        .fifo_rempty_i(fifo_rempty),
        .pop_i        (buf_pop),
        .head_valid_o (head_valid),
        .head_byte_o  (head_byte),
        .head_last_o  (head_last),
        .incoming_o   (incoming)
    );

    // A word landing this cycle counts, so DATA is entered with the head ready
    assign buf_avail = head_valid || incoming;
    assign cnt_inc   = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign last_hs   = m_tvalid && m_tready && m_tlast;

    assign frame_done = done_q;
    assign frame_len  = len_q;
    assign busy       = (state_q != StIdle) || head_valid;

    // Next-state, byte/gap counters and stream outputs
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        gap_d    = gap_q;
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        buf_pop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (buf_avail) state_d = StData;
            end
            StData: begin
                m_tvalid = head_valid;
                m_tdata  = head_valid ? head_byte : 8'h00;
                m_tlast  = head_valid && head_last && (cnt_inc >= MIN_LEN_W);
                if (head_valid && m_tready) begin
                    buf_pop = 1'b1;
                    count_d = cnt_inc;
                    if (head_last) begin
                        if (m_tlast) begin
                            state_d = StGap;
                            gap_d   = '0;
                            count_d = '0;
                        end else begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                m_tvalid = 1'b1;
                m_tlast  = (cnt_inc >= MIN_LEN_W);
                if (m_tready) begin
                    count_d = cnt_inc;
                    if (m_tlast) begin
                        state_d = StGap;
                        gap_d   = '0;
                        count_d = '0;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = buf_avail ? StData : StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and the registered frame-completion report
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= StIdle;
            count_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            done_q  <= last_hs;
            if (last_hs) len_q <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_eth_tx_fifo_drain.sv
// Self-checking bench: FIFO model, scoreboard of expected beats and frame lengths.
module tb_eth_tx_fifo_drain;

    localparam int MinLen = 60;
    localparam int Ifg    = 12;

    logic        rclk;
    logic        rrst;
    logic        fifo_rinc;
    logic [8:0]  fifo_rdata;
    logic        fifo_rempty;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        frame_done;
    logic [10:0] frame_len;
    logic        busy;

    eth_tx_fifo_drain #(
        .DSIZE     (9),
        .MIN_LEN   (MinLen),
        .IFG_CYCLES(Ifg),
        .LEN_W     (11)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_rinc  (fifo_rinc),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] fq[$];     // FIFO contents
    logic [8:0] frm[$];    // words of the frame being built
    logic [8:0] exp_q[$];  // expected {last, byte} beats
    int         len_q[$];  // expected frame_len values

    bit bp_mode = 1'b0;
    int cyc = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int first_cyc = 0;
    int tlast_cyc = 0;
    int gap_len = 0;
    int idle_run = 0;
    bit in_frame = 1'b0;
    bit after_last = 1'b0;
    bit last_hs_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Non-fall-through FIFO read port
    always @(posedge rclk) begin
        if (fifo_rinc && fq.size() > 0) fifo_rdata <= fq.pop_front();
        fifo_rempty <= (fq.size() == 0);
    end

    // MAC ready: always 1, or toggling each cycle in backpressure mode
    always @(posedge rclk) begin
        #1;
        m_tready = bp_mode ? !m_tready : 1'b1;
    end

    // Stream monitor and scoreboard
    always @(negedge rclk) begin
        cyc++;
        if (!rrst) begin
            if (fifo_rinc) check_eq("rinc_while_empty", fifo_rempty, 1'b0);
            if (frame_done || last_hs_prev) check_eq("done_timing", frame_done, last_hs_prev);
            if (frame_done) begin
                done_cnt++;
                if (len_q.size() == 0) check_eq("len_queue", len_q.size(), 1);
                else check_eq("frame_len", frame_len, len_q.pop_front());
            end
            last_hs_prev = 1'b0;
            if (m_tvalid) begin
                if (after_last) begin
                    gap_len    = idle_run;
                    after_last = 1'b0;
                    check_eq("ifg_min", idle_run >= Ifg, 1'b1);
                end
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    first_cyc = cyc;
                end
                if (exp_q.size() == 0) check_eq("beat_queue", exp_q.size(), 1);
                else check_eq("beat", {m_tlast, m_tdata}, exp_q[0]);
                if (m_tready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    beats_seen++;
                    if (m_tlast) begin
                        last_hs_prev = 1'b1;
                        tlast_cyc    = cyc;
                        in_frame     = 1'b0;
                        after_last   = 1'b1;
                        idle_run     = 0;
                    end
                end
            end else if (after_last) begin
                idle_run++;
            end
        end else begin
            last_hs_prev = 1'b0;
            in_frame     = 1'b0;
            after_last   = 1'b0;
        end
    end

    task automatic build_frame(input int n);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            frm.push_back({i == n - 1, b});
            exp_q.push_back({(i == n - 1) && (n >= MinLen), b});
        end
        for (int i = n; i < MinLen; i++) exp_q.push_back({i == MinLen - 1, 8'h00});
        len_q.push_back((n >= MinLen) ? n : MinLen);
    endtask

    task automatic feed(input int lo, input int hi);
        @(negedge rclk);
        for (int i = lo; i < hi; i++) fq.push_back(frm[i]);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge rclk);
            #1;
            k++;
        end
        check_eq("done_count", done_cnt, target);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (beats_seen < target && k < budget) begin
            @(posedge rclk);
            #1;
            k++;
        end
        check_eq("beat_count", beats_seen, target);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_tvalid"}, m_tvalid, 1'b0);
        check_eq({tag, "_tlast"}, m_tlast, 1'b0);
        check_eq({tag, "_tdata"}, m_tdata, 8'h00);
        check_eq({tag, "_done"}, frame_done, 1'b0);
        check_eq({tag, "_len"}, frame_len, 11'd0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_rinc"}, fifo_rinc, 1'b0);
    endtask

    initial begin
        int t0;
        int b0;
        rrst = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        rrst = 1'b0;
        @(negedge rclk);
        check_quiet("reset");

        // Nominal 64-byte frame: latency 2, 64 contiguous beats
        build_frame(64);
        feed(0, 64);
        @(posedge rclk);
        #1;
        t0 = cyc + 1;
        wait_done(1, 2000);
        check_eq("first_latency", first_cyc - t0, 2);
        check_eq("contiguous", tlast_cyc - first_cyc, 63);

        // Runt frame padded to 60
        b0 = beats_seen;
        build_frame(10);
        feed(0, 10);
        wait_done(2, 2000);
        check_eq("runt_beats", beats_seen - b0, MinLen);

        // Backpressure over a 100-byte frame
        bp_mode = 1'b1;
        build_frame(100);
        feed(0, 100);
        wait_done(3, 4000);
        bp_mode = 1'b0;

        // Back-to-back frames: exact gap
        build_frame(61);
        feed(0, 61);
        build_frame(70);
        feed(0, 70);
        wait_done(5, 4000);
        check_eq("ifg_exact", gap_len, Ifg);

        // Underrun after byte 20 of an 80-byte frame
        b0 = beats_seen;
        build_frame(80);
        feed(0, 20);
        wait_beats(b0 + 20, 2000);
        for (int k = 0; k < 5; k++) begin
            @(negedge rclk);
            check_eq("underrun_tvalid", m_tvalid, 1'b0);
        end
        feed(20, 80);
        wait_done(6, 2000);

        // Reset at byte 30, then a fresh frame
        b0 = beats_seen;
        build_frame(64);
        feed(0, 64);
        wait_beats(b0 + 30, 2000);
        rrst = 1'b1;
        fq.delete();
        exp_q.delete();
        len_q.delete();
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        @(negedge rclk);
        check_quiet("midreset");
        build_frame(64);
        feed(0, 64);
        wait_done(7, 2000);

        repeat (20) @(posedge rclk);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("len_empty", len_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_fifo_drain.md
# eth_tx_fifo_drain

Read-side consumer of the Ethernet TX clock-crossing FIFO. It pops 9-bit words `{last, byte}` from the FIFO read port and turns them into a byte stream (valid/ready/last) for the TX MAC. On the way it pads runt frames to the minimum length and enforces an inter-frame gap. It lives entirely in the FIFO read clock domain.

## Interface
Parameters:
- `DSIZE`, 9: FIFO word width. Bit 8 = last-of-frame, bits 7:0 = data byte. Only 9 is legal.
- `MIN_LEN`, 60: minimum frame length in bytes (excludes FCS). Shorter frames are zero-padded.
- `IFG_CYCLES`, 12: idle cycles forced after each frame.
- `LEN_W`, 11: width of the byte counter and `frame_len`.

Ports:
- `rclk`, in, 1: clock (the FIFO read clock).
- `rrst`, in, 1: reset. Synchronous, active-high.
- `fifo_rinc`, out, 1: FIFO pop request.
- `fifo_rdata`, in, DSIZE: FIFO read data. Valid one `rclk` after `fifo_rinc` (FIFO built non-fall-through).
- `fifo_rempty`, in, 1: FIFO empty flag.
- `m_tdata`, out, 8: stream byte.
- `m_tvalid`, out, 1: stream valid.
- `m_tready`, in, 1: MAC ready.
- `m_tlast`, out, 1: final byte of frame, including pad.
- `frame_done`, out, 1: one-cycle pulse per completed frame.
- `frame_len`, out, LEN_W: byte count of the last completed frame, pad included.
- `busy`, out, 1: state ≠ IDLE, or prefetch buffer non-empty.

## Operation
- **Prefetch buffer.** 2 entries, each holding `{last, byte}`.
- **Pop rule.** `fifo_rinc = !fifo_rempty && (occupancy + inflight) < 2`.
  - `inflight` = `fifo_rinc` registered; that word is written into the buffer on the following cycle.
  - Prefetch runs in every state, so words of the next frame may be buffered during PAD or GAP.
  - `fifo_rinc` never asserts while `fifo_rempty` = 1.
- **IDLE.** `m_tvalid` = 0. Go to DATA when the buffer is non-empty.
- **DATA.**
  - `m_tvalid` = buffer non-empty; `m_tdata` = head byte.
  - A handshake (`m_tvalid && m_tready`) pops the head and increments the byte count. The count saturates at 2^LEN_W−1; there is no truncation.
  - If the buffer runs empty mid-frame (FIFO underrun), `m_tvalid` drops and the block waits indefinitely. There is no timeout.
- **Handshake on a head word with last = 1:**
  - If count+1 ≥ MIN_LEN: `m_tlast` = 1 on that beat, then go to GAP.
  - Otherwise: `m_tlast` = 0 on that beat, then go to PAD.
- **PAD.** `m_tvalid` = 1, `m_tdata` = 0x00. Count advances per handshake. `m_tlast` = 1 on the beat where count+1 = MIN_LEN; after that handshake, go to GAP.
- **GAP.** `m_tvalid` = 0 for exactly IFG_CYCLES cycles. Then go to DATA if the buffer is non-empty, else IDLE.
- **Frame completion.** The cycle after the `m_tlast` handshake:
  - `frame_done` = 1.
  - `frame_len` ← final count, held until the next `frame_done`.
  - The count clears.
- **Stream stability.** While `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` are held stable. `m_tvalid` does not drop until the handshake, except in DATA on underrun, which cannot occur with a valid head.
- **Reset.** `rrst` applied on any cycle (including mid-frame) gives, on the next cycle:
  - state IDLE, buffer empty, inflight cleared, counters 0;
  - all outputs 0, including `frame_len`.
  - A word popped in the reset cycle is discarded. `rrst` must therefore be asserted together with the FIFO read-side reset.

## Timing
- **First-byte latency.** FIFO goes non-empty at cycle 0 (no frame in progress) → `fifo_rinc` at cycle 0, word buffered at cycle 1, `m_tvalid` = 1 at cycle 2.
- **Throughput.** 1 byte/cycle sustained with `m_tready` = 1 and the FIFO non-empty.
- **Gap.** Between a `m_tlast` handshake and the next frame's first `m_tvalid`: at least IFG_CYCLES idle cycles, and exactly IFG_CYCLES when the next word is already buffered.
- **`frame_done` / `frame_len`.** Both registered: they appear 1 cycle after the `m_tlast` handshake.
- **Simultaneity.** A pop and a buffer write in the same cycle are both honoured; occupancy is unchanged.

## Structure
- **Package `eth_tx_pkg`.**
  - State enum {IDLE, DATA, PAD, GAP}.
  - `LAST_BIT` = 8.
  - Default `MIN_LEN` (60) and `IFG_CYCLES` (12).
- **Sub-module `rd_prefetch_buf`.** The 2-entry buffer. It owns occupancy and inflight tracking and generates `fifo_rinc`.
- **Top level.** Holds the FSM, the byte counter and the gap counter.

## Test plan
- **Nominal frame.** 64-byte frame, `m_tready` = 1 → 64 contiguous beats, data matches, `m_tlast` on beat 64, `frame_len` = 64, `frame_done` pulses once.
- **Runt padding.** 10-byte frame → 10 data beats plus 50 beats of 0x00, `m_tlast` on beat 60, `frame_len` = 60.
- **Backpressure.** `m_tready` toggles 1/0 over a 100-byte frame → no loss or duplication, data stable while stalled, `fifo_rinc` never asserted while `fifo_rempty` = 1.
- **Back-to-back frames.** 61-byte and 70-byte frames queued → exactly 12 `m_tvalid` = 0 cycles between the first `m_tlast` handshake and byte 0 of the second frame.
- **Underrun.** FIFO empties for 5 cycles after byte 20 → `m_tvalid` low for ≥5 cycles, then resumes; `frame_len` is correct.
- **Reset mid-frame.** `rrst` pulse at byte 30 → next cycle: all outputs 0, `busy` = 0. After the FIFO is reset and refilled, a new frame streams normally.
